pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Combines three hazard sources into one prioritised set of controls for the PC, IF/ID and ID/EX registers: the data-cache miss freeze, the load-use bubble and the taken-branch flush.
- Contains a memory-wait FSM with a timeout watchdog and saturating performance counters.
- Sits beside the hazard-detection and branch logic in ID and the data cache in MEM.

---
 rtl/pipe_hazard_ctrl_if.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 64 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX/MEM and the stall/flush controls back to the pipe
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rd_i;
  logic [4:0]       IFID_Rs1_i;
  logic [4:0]       IFID_Rs2_i;
  logic             Branch_taken_i;
  logic             Mem_req_i;
  logic             Mem_hit_i;
  logic             Mem_ack_i;
  logic             PC_write_o;
  logic             IFID_Stall_o;
  logic             IFID_Flush_o;
  logic             IDEX_Bubble_o;
  logic             Freeze_o;
  logic             Timeout_err_o;
  logic [CNT_W-1:0] Stall_cnt_o;
  logic [CNT_W-1:0] Flush_cnt_o;
  modport slave (
    input  IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i, Branch_taken_i, Mem_req_i, Mem_hit_i, Mem_ack_i,
    output PC_write_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, Timeout_err_o, Stall_cnt_o, Flush_cnt_o
  );
  modport master (
    output IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i, Branch_taken_i, Mem_req_i, Mem_hit_i, Mem_ack_i,
    input  PC_write_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, Timeout_err_o, Stall_cnt_o, Flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised freeze/load-use/flush sequencer with memory-wait FSM, watchdog and counters
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {IDLE, WAIT, REPLAY} state_t;
  state_t           r_st, w_nx;
  logic [TO_W-1:0]  r_wcnt;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic             r_err;
  logic             w_luh, w_frz, w_to, w_flush;
  assign w_luh = h.IDEX_MemRead_i && (h.IDEX_Rd_i != 5'd0) &&
                 ((h.IDEX_Rd_i == h.IFID_Rs1_i) || (h.IDEX_Rd_i == h.IFID_Rs2_i));
  always_comb begin
    w_nx  = r_st;
    w_frz = 1'b0;
    w_to  = 1'b0;
    case (r_st)
      IDLE: begin
        w_frz = h.Mem_req_i && !h.Mem_hit_i;
        w_nx  = w_frz ? WAIT : IDLE;
      end
      WAIT: begin
        w_frz = 1'b1;
        w_to  = !h.Mem_ack_i && (r_wcnt == TO_W'(TIMEOUT));
        w_nx  = h.Mem_ack_i ? REPLAY : (w_to ? IDLE : WAIT);
      end
      default: begin
        w_frz = 1'b1;
        w_nx  = IDLE;
      end
    endcase
  end
  assign w_flush = !w_frz && !w_luh && h.Branch_taken_i;
  // the wait counter only runs in WAIT, so it is zero on every fresh miss
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_st    <= IDLE;
      r_wcnt  <= '0;
      r_stall <= '0;
      r_flush <= '0;
      r_err   <= 1'b0;
    end else begin
      r_st   <= w_nx;
      r_wcnt <= (r_st == WAIT) ? r_wcnt + 1'b1 : '0;
      if ((w_frz || w_luh) && !(&r_stall)) r_stall <= r_stall + 1'b1;
      if (w_flush && !(&r_flush)) r_flush <= r_flush + 1'b1;
      if (w_to) r_err <= 1'b1;
    end
  end
  assign h.Freeze_o      = w_frz;
  assign h.PC_write_o    = !w_frz && !w_luh;
  assign h.IFID_Stall_o  = w_frz || w_luh;
  assign h.IDEX_Bubble_o = !w_frz && w_luh;
  assign h.IFID_Flush_o  = w_flush;
  assign h.Timeout_err_o = r_err;
  assign h.Stall_cnt_o   = r_stall;
  assign h.Flush_cnt_o   = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks on a default instance and a short-timeout, 4-bit-counter instance
module tb_pipe_hazard_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n, bad;
  always #5 clk_i = ~clk_i;
  pipe_hazard_ctrl_if #(.CNT_W(32)) a();
  pipe_hazard_ctrl_if #(.CNT_W(4))  b();
  assign b.IDEX_MemRead_i = a.IDEX_MemRead_i;
  assign b.IDEX_Rd_i      = a.IDEX_Rd_i;
  assign b.IFID_Rs1_i     = a.IFID_Rs1_i;
  assign b.IFID_Rs2_i     = a.IFID_Rs2_i;
  assign b.Branch_taken_i = a.Branch_taken_i;
  assign b.Mem_req_i      = a.Mem_req_i;
  assign b.Mem_hit_i      = a.Mem_hit_i;
  assign b.Mem_ack_i      = a.Mem_ack_i;
  pipe_hazard_ctrl #(.TIMEOUT(255), .TO_W(8), .CNT_W(32)) u_main (.clk_i(clk_i), .rst_i(rst_i), .h(a));
  pipe_hazard_ctrl #(.TIMEOUT(4),   .TO_W(8), .CNT_W(4))  u_to   (.clk_i(clk_i), .rst_i(rst_i), .h(b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask
  task automatic smp();
    @(negedge clk_i);
  endtask
  task automatic clr();
    a.IDEX_MemRead_i = 1'b0;
    a.IDEX_Rd_i = 5'd0;
    a.IFID_Rs1_i = 5'd0;
    a.IFID_Rs2_i = 5'd0;
    a.Branch_taken_i = 1'b0;
    a.Mem_req_i = 1'b0;
    a.Mem_hit_i = 1'b0;
    a.Mem_ack_i = 1'b0;
  endtask
  initial begin
    clr();
    nxt(); nxt();
    rst_i = 1'b1;
    smp();
    chk("rst_pcw", 32'(a.PC_write_o), 1);
    chk("rst_stall", 32'(a.IFID_Stall_o), 0);
    chk("rst_flush", 32'(a.IFID_Flush_o), 0);
    chk("rst_bubble", 32'(a.IDEX_Bubble_o), 0);
    chk("rst_freeze", 32'(a.Freeze_o), 0);
    chk("rst_err", 32'(a.Timeout_err_o), 0);
    chk("rst_scnt", a.Stall_cnt_o, 0);
    chk("rst_fcnt", a.Flush_cnt_o, 0);
    nxt();
    a.IDEX_MemRead_i = 1'b1; a.IDEX_Rd_i = 5'd5; a.IFID_Rs2_i = 5'd5;
    smp();
    chk("luh_pcw", 32'(a.PC_write_o), 0);
    chk("luh_stall", 32'(a.IFID_Stall_o), 1);
    chk("luh_bubble", 32'(a.IDEX_Bubble_o), 1);
    nxt();
    a.IDEX_Rd_i = 5'd0; a.IFID_Rs2_i = 5'd0;
    smp();
    chk("luh_scnt1", a.Stall_cnt_o, 1);
    chk("rd0_pcw", 32'(a.PC_write_o), 1);
    chk("rd0_bubble", 32'(a.IDEX_Bubble_o), 0);
    nxt();
    a.IDEX_Rd_i = 5'd7; a.IFID_Rs1_i = 5'd7; a.Branch_taken_i = 1'b1;
    smp();
    chk("lubr_flush", 32'(a.IFID_Flush_o), 0);
    chk("lubr_bubble", 32'(a.IDEX_Bubble_o), 1);
    nxt();
    clr();
    a.Mem_req_i = 1'b1; a.Mem_hit_i = 1'b1; a.Mem_ack_i = 1'b1;
    smp();
    chk("hit_freeze", 32'(a.Freeze_o), 0);
    chk("scnt2", a.Stall_cnt_o, 2);
    chk("fcnt0", a.Flush_cnt_o, 0);
    nxt();
    clr();
    a.Mem_req_i = 1'b1; a.Branch_taken_i = 1'b1;
    n = 0; bad = 0;
    smp();
    while (a.Freeze_o && n < 20) begin
      n++;
      if (a.IFID_Flush_o || a.PC_write_o) bad++;
      nxt();
      a.Mem_req_i = 1'b0;
      a.Mem_ack_i = (n == 10);
    smp();
    end
    chk("miss_frz_cycles", n, 12);
    chk("miss_flush_while_frz", bad, 0);
    chk("miss_flush_after", 32'(a.IFID_Flush_o), 1);
    chk("miss_pcw_after", 32'(a.PC_write_o), 1);
    nxt();
    clr();
    smp();
    chk("miss_fcnt", a.Flush_cnt_o, 1);
    chk("miss_scnt", a.Stall_cnt_o, 14);
    chk("miss_err", 32'(a.Timeout_err_o), 0);
    nxt();
    a.Mem_ack_i = 1'b1;
    smp();
    chk("idle_ack_freeze", 32'(a.Freeze_o), 0);
    nxt();
    clr();
    rst_i = 1'b0;
    nxt();
    rst_i = 1'b1;
    a.Mem_req_i = 1'b1;
    n = 0; bad = 0;
    smp();
    while (b.Freeze_o && n < 20) begin
      n++;
      if (b.Timeout_err_o) bad++;
      nxt();
      a.Mem_req_i = 1'b0;
    smp();
    end
    chk("to_frz_cycles", n, 6);
    chk("to_err_early", bad, 0);
    chk("to_err", 32'(b.Timeout_err_o), 1);
    chk("to_pcw", 32'(b.PC_write_o), 1);
    chk("to_scnt", b.Stall_cnt_o, 6);
    for (int i = 0; i < 12; i++) begin
      a.IDEX_MemRead_i = 1'b1; a.IDEX_Rd_i = 5'd3; a.IFID_Rs1_i = 5'd3;
      nxt();
    end
    clr();
    smp();
    chk("to_err_sticky", 32'(b.Timeout_err_o), 1);
    chk("scnt_saturate", b.Stall_cnt_o, 15);
    nxt();
    rst_i = 1'b0;
    nxt();
    rst_i = 1'b1;
    smp();
    chk("to_err_rst", 32'(b.Timeout_err_o), 0);
    chk("to_scnt_rst", b.Stall_cnt_o, 0);
    nxt();
    a.Mem_req_i = 1'b1;
    n = 0;
    smp();
    while (b.Freeze_o && n < 20) begin
      n++;
      nxt();
      a.Mem_req_i = 1'b0;
      a.Mem_ack_i = (n == 5);
    smp();
    end
    chk("ackto_frz_cycles", n, 7);
    chk("ackto_err", 32'(b.Timeout_err_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
